// File: rtl/div_unit_pkg.sv
// Shared constants for the EX-stage divider.
//   RESET_ENABLE      : level of rst that means "in reset"
//   StallBus          : pipeline stall bus type (PC/IF/ID/EX/MEM/WB)
//   div_state_t       : divider FSM encodings, DivFree must stay 2'b00
//   DivStart/DivStop  : div_start levels
//   DivResultReady/DivResultNotReady : ready levels
package div_unit_pkg;

  localparam logic RESET_ENABLE = 1'b1;

  typedef logic [5:0] StallBus;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Ports:
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   div_start  : divide request, held by EX until ready
//   signed_div : 1 = signed, 0 = unsigned
//   opdata1    : dividend
//   opdata2    : divisor
//   annul      : abort current operation
//   result     : {remainder, quotient}
//   ready      : result valid (registered)
//   stallreq   : stall request to the pipeline controller (combinational)
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opdata1,
  input  logic [WIDTH-1:0]   opdata2,
  input  logic               annul,
  output logic [2*WIDTH-1:0] result,
  output logic               ready,
  output logic               stallreq
);

  div_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] rem_reg;     // partial remainder
  logic [WIDTH-1:0] dvd_reg;     // dividend bits shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvs_reg;     // |divisor|
  logic             sign_a_reg;
  logic             sign_b_reg;
  logic             signed_reg;

  // Magnitudes of the incoming operands; only signed negatives are negated.
  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  assign abs_a = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
  assign abs_b = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;

  // One restoring step: shift the next dividend bit into the remainder and
  // try subtracting the divisor. trial[WIDTH] set means the subtraction
  // went negative and the old (shifted) remainder is kept.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_dvd;
  assign rem_shift = {rem_reg, dvd_reg[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvs_reg};
  assign step_rem  = trial[WIDTH] ? rem_shift[WIDTH-1:0] : trial[WIDTH-1:0];
  assign step_dvd  = {dvd_reg[WIDTH-2:0], ~trial[WIDTH]};

  // Sign fixup after the last step. The most negative dividend over -1
  // wraps back to itself, which is the intended no-trap behaviour.
  logic [WIDTH-1:0] fix_q;
  logic [WIDTH-1:0] fix_r;
  assign fix_q = (signed_reg && (sign_a_reg ^ sign_b_reg)) ? -dvd_reg : dvd_reg;
  assign fix_r = (signed_reg && sign_a_reg) ? -rem_reg : rem_reg;

  assign stallreq = div_start & ~ready & ~annul;

  always_ff @(posedge clk) begin
    if (rst == RESET_ENABLE) begin
      state_reg  <= DivFree;
      cnt_reg    <= '0;
      rem_reg    <= '0;
      dvd_reg    <= '0;
      dvs_reg    <= '0;
      sign_a_reg <= 1'b0;
      sign_b_reg <= 1'b0;
      signed_reg <= 1'b0;
      result     <= '0;
      ready      <= DivResultNotReady;
    end else begin
      case (state_reg)
        DivFree: begin
          ready  <= DivResultNotReady;
          result <= '0;
          if (div_start == DivStart && !annul) begin
            if (opdata2 == '0) begin
              state_reg <= DivByZero;
            end else begin
              state_reg  <= DivOn;
              cnt_reg    <= '0;
              rem_reg    <= '0;
              dvd_reg    <= abs_a;
              dvs_reg    <= abs_b;
              sign_a_reg <= opdata1[WIDTH-1];
              sign_b_reg <= opdata2[WIDTH-1];
              signed_reg <= signed_div;
            end
          end
        end
        DivByZero: begin
          state_reg <= DivEnd;
          result    <= '0;
          ready     <= DivResultReady;
        end
        DivOn: begin
          if (annul) begin
            state_reg <= DivFree;
            ready     <= DivResultNotReady;
          end else if (cnt_reg != CNT_W'(WIDTH)) begin
            rem_reg <= step_rem;
            dvd_reg <= step_dvd;
            cnt_reg <= cnt_reg + 1'b1;
          end else begin
            result    <= {fix_r, fix_q};
            ready     <= DivResultReady;
            state_reg <= DivEnd;
            cnt_reg   <= '0;
          end
        end
        DivEnd: begin
          // Result is held until EX drops the request.
          if (div_start == DivStop || annul) begin
            state_reg <= DivFree;
            ready     <= DivResultNotReady;
            result    <= '0;
          end
        end
        default: state_reg <= DivFree;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_start;
  logic        signed_div;
  logic        annul;
  logic [31:0] opdata1;
  logic [31:0] opdata2;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_start  (div_start),
    .signed_div (signed_div),
    .opdata1    (opdata1),
    .opdata2    (opdata2),
    .annul      (annul),
    .result     (result),
    .ready      (ready),
    .stallreq   (stallreq)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: truncating division on wide signed integers.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    sa = s ? {{32{a[31]}}, a} : {32'd0, a};
    sb = s ? {{32{b[31]}}, b} : {32'd0, b};
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Transaction-level timing model: 33 edges after acceptance for a real
  // divide, 1 edge for a zero divisor; result held while start stays high.
  int          m_phase = 0;   // 0 idle, 1 busy, 2 done
  int          m_wait  = 0;
  bit          m_zero  = 0;
  bit          m_valid = 0;
  logic        m_ready = 1'b0;
  logic [63:0] m_result = '0;
  logic [63:0] m_pend   = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_ready = 1'b0; m_result = '0; m_valid = 1;
    end else begin
      case (m_phase)
        0: begin
          m_ready = 1'b0; m_result = '0;
          if (div_start && !annul) begin
            m_pend  = ref_div(opdata1, opdata2, signed_div);
            m_zero  = (opdata2 == 32'd0);
            m_wait  = m_zero ? 1 : 33;
            m_phase = 1;
          end
        end
        1: begin
          if (annul && !m_zero) begin
            m_phase = 0; m_ready = 1'b0;
          end else begin
            m_wait--;
            if (m_wait == 0) begin
              m_ready = 1'b1; m_result = m_pend; m_phase = 2;
            end
          end
        end
        default: begin
          if (!div_start || annul) begin
            m_phase = 0; m_ready = 1'b0; m_result = '0;
          end
        end
      endcase
    end
    #1;
    if (m_valid) begin
      check("model_ready", {63'd0, ready}, {63'd0, m_ready});
      check("model_result", result, m_result);
      check("model_stallreq", {63'd0, stallreq}, {63'd0, div_start & ~m_ready & ~annul});
    end
  end

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp_res, input int exp_cyc);
    int cyc = 0;
    int stalls = 0;
    check({name, "_refmodel"}, ref_div(a, b, s), exp_res);
    @(negedge clk);
    opdata1 = a; opdata2 = b; signed_div = s; annul = 1'b0; div_start = 1'b1;
    do begin
      @(posedge clk); #1;
      cyc++;
      if (!ready && stallreq) stalls++;
    end while (!ready && cyc < 100);
    if (!ready) begin
      errors++;
      $display("FAIL %s_timeout actual=no_ready required=ready within 100 cycles", name);
    end
    check({name, "_latency"}, 64'(cyc), 64'(exp_cyc));
    check({name, "_result"}, result, exp_res);
    check({name, "_stallcycles"}, 64'(stalls), 64'(exp_cyc - 1));
    $display("op %s a=%h b=%h signed=%0d result=%h cycles=%0d stall=%0d",
             name, a, b, s, result, cyc, stalls);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    div_start = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; div_start = 1'b0; signed_div = 1'b0; annul = 1'b0;
    opdata1 = '0; opdata2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", {63'd0, ready}, 64'd0);
    check("reset_result", result, 64'd0);
    check("reset_stallreq", {63'd0, stallreq}, 64'd0);
    @(negedge clk); rst = 1'b0;

    run_op("u100_7", 32'd100, 32'd7, 1'b0, {32'h2, 32'hE}, 34); idle(2);
    run_op("s_m7_2", 32'hFFFFFFF9, 32'h2, 1'b1, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34); idle(2);
    run_op("s_7_m2", 32'h7, 32'hFFFFFFFE, 1'b1, {32'h1, 32'hFFFFFFFD}, 34); idle(2);
    run_op("byzero", 32'h1234, 32'h0, 1'b0, 64'd0, 2); idle(2);
    run_op("s_ovf", 32'h80000000, 32'hFFFFFFFF, 1'b1, {32'h0, 32'h80000000}, 34); idle(2);
    run_op("u_max_1", 32'hFFFFFFFF, 32'h1, 1'b0, {32'h0, 32'hFFFFFFFF}, 34); idle(2);

    // Annul in the middle of the iteration.
    @(negedge clk);
    opdata1 = 32'd100; opdata2 = 32'd7; signed_div = 1'b0; div_start = 1'b1;
    repeat (11) @(posedge clk);
    @(negedge clk); annul = 1'b1;
    #1 check("annul_stallreq", {63'd0, stallreq}, 64'd0);
    @(posedge clk); #1 check("annul_ready", {63'd0, ready}, 64'd0);
    @(negedge clk); annul = 1'b0; div_start = 1'b0;
    @(posedge clk); #1 check("annul_ready_after", {63'd0, ready}, 64'd0);
    $display("op annul_mid_on ready=%0d stallreq=%0d", ready, stallreq);
    run_op("u9_3", 32'd9, 32'd3, 1'b0, {32'h0, 32'h3}, 34); idle(2);

    // Reset in the middle of the iteration.
    @(negedge clk);
    opdata1 = 32'd50; opdata2 = 32'd5; signed_div = 1'b0; div_start = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk); rst = 1'b1; div_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_ready", {63'd0, ready}, 64'd0);
    check("midrst_result", result, 64'd0);
    check("midrst_stallreq", {63'd0, stallreq}, 64'd0);
    $display("op reset_mid_on ready=%0d result=%h", ready, result);
    @(negedge clk); rst = 1'b0;

    // Hold in END, drop start for one cycle, then a new operation.
    run_op("u1000_33", 32'd1000, 32'd33, 1'b0, {32'd10, 32'd30}, 34);
    repeat (3) begin
      @(posedge clk); #1 check("end_hold_ready", {63'd0, ready}, 64'd1);
    end
    @(negedge clk); div_start = 1'b0;
    @(posedge clk); #1 check("end_drop_ready", {63'd0, ready}, 64'd0);
    run_op("u_dead_16", 32'hDEADBEEF, 32'h10, 1'b0, {32'hF, 32'h0DEADBEE}, 34); idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
